macro_decoder_onehot_pipe: RTL and testbench



---
 rtl/macro_onehot_pkg.sv | 13 +
 rtl/macro_decoder_onehot_bin.sv | 19 +
 rtl/macro_decoder_onehot_pipe.sv | 120 ++++++++++++
 tb/tb_macro_decoder_onehot_pipe.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/macro_onehot_pkg.sv
// Shared constants for the one-hot decode pipeline: default index width and
// the skid-buffer occupancy encoding.
package macro_onehot_pkg;

  localparam int ONEHOT_BIN_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    CNT_EMPTY = 2'd0,
    CNT_ONE   = 2'd1,
    CNT_FULL  = 2'd2
  } cnt_e;

endpackage

// File: rtl/macro_decoder_onehot_bin.sv
// Combinational binary-to-one-hot decoder; indices >= OUTPUT_WIDTH decode to
// all zeros and drop in_range.
module macro_decoder_onehot_bin #(
  parameter int INPUT_WIDTH  = 4,
  parameter int OUTPUT_WIDTH = 1 << INPUT_WIDTH
) (
  input  logic [INPUT_WIDTH-1:0]  d,
  output logic [OUTPUT_WIDTH-1:0] q,
  output logic                    in_range
);

  always_comb begin
    for (int k = 0; k < OUTPUT_WIDTH; k++) begin
      q[k] = (int'(d) == k);
    end
    in_range = (int'(d) < OUTPUT_WIDTH);
  end

endmodule

// File: rtl/macro_decoder_onehot_pipe.sv
// Registered binary-to-one-hot decoder with a 2-entry skid buffer; all outputs from flops.
// Optional out-of-range drop + sticky err under MACRO_DECODER_ONEHOT_RANGE_CHECK_EN.
module macro_decoder_onehot_pipe
  import macro_onehot_pkg::*;
#(
  parameter int INPUT_WIDTH  = ONEHOT_BIN_WIDTH_DEFAULT,
  parameter int OUTPUT_WIDTH = 1 << INPUT_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_valid,
  output logic                    i_ready,
  input  logic [INPUT_WIDTH-1:0]  i_d,
  output logic                    o_valid,
  input  logic                    o_ready,
  output logic [OUTPUT_WIDTH-1:0] o_q,
  output logic                    err
);

  logic [OUTPUT_WIDTH-1:0] dec_vec;
  logic                    in_range;

  macro_decoder_onehot_bin #(
    .INPUT_WIDTH (INPUT_WIDTH),
    .OUTPUT_WIDTH(OUTPUT_WIDTH)
  ) u_bin (
    .d       (i_d),
    .q       (dec_vec),
    .in_range(in_range)
  );

  cnt_e                    cnt_q, cnt_d;
  logic [OUTPUT_WIDTH-1:0] head_q, head_d;
  logic [OUTPUT_WIDTH-1:0] tail_q, tail_d;
  logic                    i_ready_q, o_valid_q;
  logic                    in_fire, out_fire, enq;

  assign in_fire  = i_valid && i_ready_q;
  assign out_fire = o_valid_q && o_ready;

`ifdef MACRO_DECODER_ONEHOT_RANGE_CHECK_EN
  logic err_q;

  assign enq = in_fire && in_range;
  assign err = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (in_fire && !in_range) begin
      err_q <= 1'b1;
    end
  end
`else
  logic unused_in_range;

  assign unused_in_range = in_range;
  assign enq             = in_fire;
  assign err             = 1'b0;
`endif

  // head_q is kept at zero whenever the buffer is empty so o_q needs no mux.
  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    case (cnt_q)
      CNT_EMPTY: begin
        if (enq) begin
          head_d = dec_vec;
          cnt_d  = CNT_ONE;
        end
      end
      CNT_ONE: begin
        if (enq && out_fire) begin
          head_d = dec_vec;
        end else if (enq) begin
          tail_d = dec_vec;
          cnt_d  = CNT_FULL;
        end else if (out_fire) begin
          head_d = '0;
          cnt_d  = CNT_EMPTY;
        end
      end
      CNT_FULL: begin
        if (out_fire) begin
          head_d = tail_q;
          tail_d = '0;
          cnt_d  = CNT_ONE;
        end
      end
      default: begin
        cnt_d  = CNT_EMPTY;
        head_d = '0;
        tail_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= CNT_EMPTY;
      head_q    <= '0;
      tail_q    <= '0;
      i_ready_q <= 1'b1;
      o_valid_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      i_ready_q <= (cnt_d != CNT_FULL);
      o_valid_q <= (cnt_d != CNT_EMPTY);
    end
  end

  assign i_ready = i_ready_q;
  assign o_valid = o_valid_q;
  assign o_q     = head_q;

endmodule

// File: tb/tb_macro_decoder_onehot_pipe.sv
// Directed bench: default 4->16 instance plus a 4->10 instance for range handling.
module tb_macro_decoder_onehot_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        i_valid = 1'b0;
  logic        i_ready;
  logic [3:0]  i_d = '0;
  logic        o_valid;
  logic        o_ready = 1'b0;
  logic [15:0] o_q;
  logic        err;

  logic        r_i_valid = 1'b0;
  logic        r_i_ready;
  logic [3:0]  r_i_d = '0;
  logic        r_o_valid;
  logic        r_o_ready = 1'b0;
  logic [9:0]  r_o_q;
  logic        r_err;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  macro_decoder_onehot_pipe u_dut (
    .clk    (clk),
    .reset  (reset),
    .i_valid(i_valid),
    .i_ready(i_ready),
    .i_d    (i_d),
    .o_valid(o_valid),
    .o_ready(o_ready),
    .o_q    (o_q),
    .err    (err)
  );

  macro_decoder_onehot_pipe #(.INPUT_WIDTH(4), .OUTPUT_WIDTH(10)) u_dut10 (
    .clk    (clk),
    .reset  (reset),
    .i_valid(r_i_valid),
    .i_ready(r_i_ready),
    .i_d    (r_i_d),
    .o_valid(r_o_valid),
    .o_ready(r_o_ready),
    .o_q    (r_o_q),
    .err    (r_err)
  );

  // Advance one rising edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    reset = 1'b0;
    tick();
    n_vec++; if (i_ready !== 1'b1) begin n_bad++; $display("FAIL reset_i_ready got %b want 1", i_ready); end
    n_vec++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_o_valid got %b want 0", o_valid); end
    n_vec++; if (o_q !== 16'h0000) begin n_bad++; $display("FAIL reset_o_q got %h want 0000", o_q); end
    n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
  endtask

  task automatic test_single();
    o_ready = 1'b1;
    i_valid = 1'b1;
    i_d     = 4'd5;
    tick();
    i_valid = 1'b0;
    n_vec++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL single_o_valid got %b want 1", o_valid); end
    n_vec++; if (o_q !== 16'h0020) begin n_bad++; $display("FAIL single_o_q got %h want 0020", o_q); end
    tick();
    n_vec++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL single_drain_valid got %b want 0", o_valid); end
    n_vec++; if (o_q !== 16'h0000) begin n_bad++; $display("FAIL single_drain_q got %h want 0000", o_q); end
  endtask

  task automatic test_stream();
    logic [15:0] exp;
    o_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      i_valid = 1'b1;
      i_d     = 4'(k);
      tick();
      exp = 16'h0001 << k;
      n_vec++; if (o_valid !== 1'b1 || o_q !== exp) begin
        n_bad++; $display("FAIL stream_%0d got v=%b q=%h want v=1 q=%h", k, o_valid, o_q, exp);
      end
      n_vec++; if (i_ready !== 1'b1) begin n_bad++; $display("FAIL stream_ready_%0d got %b want 1", k, i_ready); end
    end
    i_valid = 1'b0;
    tick();
    n_vec++; if (o_valid !== 1'b0 || o_q !== 16'h0000) begin
      n_bad++; $display("FAIL stream_end got v=%b q=%h want v=0 q=0000", o_valid, o_q);
    end
  endtask

  task automatic test_backpressure();
    o_ready = 1'b0;
    i_valid = 1'b1;
    i_d     = 4'd3;
    tick();
    n_vec++; if (o_q !== 16'h0008 || i_ready !== 1'b1) begin
      n_bad++; $display("FAIL bp_first got q=%h rdy=%b want q=0008 rdy=1", o_q, i_ready);
    end
    i_d = 4'd7;
    tick();
    n_vec++; if (o_q !== 16'h0008 || i_ready !== 1'b0 || o_valid !== 1'b1) begin
      n_bad++; $display("FAIL bp_full got q=%h rdy=%b v=%b want q=0008 rdy=0 v=1", o_q, i_ready, o_valid);
    end
    i_d = 4'd9;
    tick();
    n_vec++; if (o_q !== 16'h0008 || i_ready !== 1'b0) begin
      n_bad++; $display("FAIL bp_hold got q=%h rdy=%b want q=0008 rdy=0", o_q, i_ready);
    end
    o_ready = 1'b1;
    tick();
    n_vec++; if (o_q !== 16'h0080 || i_ready !== 1'b1) begin
      n_bad++; $display("FAIL bp_out1 got q=%h rdy=%b want q=0080 rdy=1", o_q, i_ready);
    end
    tick();
    i_valid = 1'b0;
    n_vec++; if (o_q !== 16'h0200 || o_valid !== 1'b1) begin
      n_bad++; $display("FAIL bp_out2 got q=%h v=%b want q=0200 v=1", o_q, o_valid);
    end
    tick();
    n_vec++; if (o_q !== 16'h0000 || o_valid !== 1'b0) begin
      n_bad++; $display("FAIL bp_drain got q=%h v=%b want q=0000 v=0", o_q, o_valid);
    end
  endtask

  task automatic test_range();
    r_o_ready = 1'b1;
    r_i_valid = 1'b1;
    r_i_d     = 4'd12;
    tick();
    r_i_d = 4'd2;
`ifdef MACRO_DECODER_ONEHOT_RANGE_CHECK_EN
    n_vec++; if (r_o_valid !== 1'b0 || r_err !== 1'b1) begin
      n_bad++; $display("FAIL range_oor got v=%b err=%b want v=0 err=1", r_o_valid, r_err);
    end
`else
    n_vec++; if (r_o_valid !== 1'b1 || r_o_q !== 10'h000 || r_err !== 1'b0) begin
      n_bad++; $display("FAIL range_oor got v=%b q=%h err=%b want v=1 q=000 err=0", r_o_valid, r_o_q, r_err);
    end
`endif
    tick();
    r_i_valid = 1'b0;
    n_vec++; if (r_o_valid !== 1'b1 || r_o_q !== 10'h004) begin
      n_bad++; $display("FAIL range_in got v=%b q=%h want v=1 q=004", r_o_valid, r_o_q);
    end
    tick();
    n_vec++; if (r_o_valid !== 1'b0) begin n_bad++; $display("FAIL range_drain got %b want 0", r_o_valid); end
`ifdef MACRO_DECODER_ONEHOT_RANGE_CHECK_EN
    n_vec++; if (r_err !== 1'b1) begin n_bad++; $display("FAIL range_sticky got %b want 1", r_err); end
`else
    n_vec++; if (r_err !== 1'b0) begin n_bad++; $display("FAIL range_err got %b want 0", r_err); end
`endif
    n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL main_err got %b want 0", err); end
  endtask

  task automatic test_mid_reset();
    o_ready = 1'b0;
    i_valid = 1'b1;
    i_d     = 4'd1;
    tick();
    i_d = 4'd2;
    tick();
    i_valid = 1'b0;
    n_vec++; if (i_ready !== 1'b0 || o_valid !== 1'b1) begin
      n_bad++; $display("FAIL mr_full got rdy=%b v=%b want rdy=0 v=1", i_ready, o_valid);
    end
    reset = 1'b1;
    #1;
    n_vec++; if (o_valid !== 1'b0 || o_q !== 16'h0000 || i_ready !== 1'b1) begin
      n_bad++; $display("FAIL mr_async got v=%b q=%h rdy=%b want v=0 q=0000 rdy=1", o_valid, o_q, i_ready);
    end
    n_vec++; if (r_err !== 1'b0) begin n_bad++; $display("FAIL mr_err_clear got %b want 0", r_err); end
    tick();
    reset   = 1'b0;
    o_ready = 1'b1;
    tick();
    n_vec++; if (o_valid !== 1'b0 || o_q !== 16'h0000) begin
      n_bad++; $display("FAIL mr_release got v=%b q=%h want v=0 q=0000", o_valid, o_q);
    end
    tick();
    n_vec++; if (o_valid !== 1'b0 || i_ready !== 1'b1) begin
      n_bad++; $display("FAIL mr_idle got v=%b rdy=%b want v=0 rdy=1", o_valid, i_ready);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_range();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
